router_pkt_fifo: RTL

- Parametrised, packet-aware synchronous FIFO for the router output ports. It replaces the fixed 16x9 destination FIFO.
- Each entry stores a data word plus a header tag. On read, the block tracks the remaining payload+parity count of the current packet and flags the final word.
- Adds simultaneous read/write, occupancy count, almost-full, sticky overflow and a registered read-valid.
- One instance per destination channel; written by the router FSM/register stage, read by the output interface.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_pkt_tracker.sv | 56 +++++
 rtl/router_pkt_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router output-port FIFOs.
package router_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_LSB_DEF = 2;
  localparam int unsigned LEN_W_DEF   = 6;
  localparam int unsigned WORD_MAX    = 32;

  typedef struct packed {
    logic                  tag;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

  // Payload-length field of a header word, right-aligned.
  function automatic logic [WORD_MAX-1:0] pkt_len(input logic [WORD_MAX-1:0] data,
                                                  input int unsigned          lsb,
                                                  input int unsigned          width);
    logic [WORD_MAX-1:0] mask;
    mask = (WORD_MAX'(1) << width) - WORD_MAX'(1);
    return (data >> lsb) & mask;
  endfunction

endpackage

// File: rtl/router_pkt_tracker.sv
// Remaining-word counter for the packet currently being read; flags the parity word.
module router_pkt_tracker
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_LSB = LEN_LSB_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              rd_accept_i,
  input  logic              tag_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pkt_last_o
);

  localparam logic [LEN_W:0] REM_ONE = 1;

  logic [LEN_W:0] remaining_q, remaining_d;
  logic [LEN_W:0] hdr_count;
  logic           pkt_last_q, pkt_last_d;

  // Header announces len payload words plus one parity word.
  assign hdr_count = (LEN_W+1)'(pkt_len(WORD_MAX'(data_i), LEN_LSB, LEN_W)) + REM_ONE;

  always_comb begin
    remaining_d = remaining_q;
    pkt_last_d  = 1'b0;
    if (flush_i) begin
      remaining_d = '0;
    end else if (rd_accept_i) begin
      if (tag_i) begin
        remaining_d = hdr_count;
      end else if (remaining_q == REM_ONE) begin
        remaining_d = '0;
        pkt_last_d  = 1'b1;
      end else if (remaining_q != '0) begin
        remaining_d = remaining_q - REM_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining_q <= '0;
      pkt_last_q  <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      pkt_last_q  <= pkt_last_d;
    end
  end

  assign pkt_last_o = pkt_last_q;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router destination channel.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LEN_LSB  = LEN_LSB_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_rst,
  input  logic                     we,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        din,
  input  logic                     re,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     pkt_last,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned    ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);

  typedef struct packed {
    logic              tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            rd_entry;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              wr_ok, rd_ok;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                       (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= AF_CNT);

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign rd_ok    = re && !empty;
  assign wr_ok    = we && (!full || re);
  assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    if (soft_rst) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      dout_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (we && !wr_ok) overflow_d = 1'b1;
      if (rd_ok) begin
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
        dout_d       = rd_entry.data;
        dout_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst && !soft_rst && wr_ok) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= '{tag: lfd_state, data: din};
    end
  end

  router_pkt_tracker #(
    .DATA_W  (DATA_W),
    .LEN_LSB (LEN_LSB),
    .LEN_W   (LEN_W)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (soft_rst),
    .rd_accept_i (rd_ok),
    .tag_i       (rd_entry.tag),
    .data_i      (rd_entry.data),
    .pkt_last_o  (pkt_last)
  );

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;

endmodule
